// File: rtl/exec_perf_counters.sv
// exec_perf_counters: retire-path per-opcode-class, total and cycle counters.
// Build with PERF_TRACE_EN for simulation-only retire and clear trace prints.
module exec_perf_counters #(
  parameter int CNT_W   = 32,
  parameter int PC_W    = 16,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               retire_valid,
  input  logic               retire_flush,
  input  logic [INSTR_W-1:0] retire_instr,
  input  logic [PC_W-1:0]    retire_pc,
  input  logic               cnt_clr,
  input  logic               cnt_freeze,
  input  logic [3:0]         rd_sel,
  output logic [CNT_W-1:0]   rd_data,
  output logic [11:0]        ovf_flags,
  output logic [PC_W-1:0]    last_pc
);

  localparam int NCNT = 12;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;

  logic [CNT_W-1:0] cnt_q [NCNT];
  logic [CNT_W-1:0] cnt_d [NCNT];
  logic [11:0]      ovf_q, ovf_d;
  logic [PC_W-1:0]  last_pc_q, last_pc_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;

  logic [6:0]      op;
  logic [3:0]      cls;
  logic [NCNT-1:0] inc;
  logic            count_en;
  logic            tick;
  logic            unused_instr;

  assign op           = retire_instr[6:0];
  assign unused_instr = ^retire_instr[INSTR_W-1:7];

  assign count_en = retire_valid & ~retire_flush
                  & ~cnt_freeze & ~cnt_clr;
  assign tick     = ~cnt_freeze & ~cnt_clr;

  always_comb begin
    cls = 4'd9;
    unique case (1'b1)
      op == OP_R:   cls = 4'd0;
      op == OP_I:   cls = 4'd1;
      op == OP_ST:  cls = 4'd2;
      op == OP_LD:  cls = 4'd3;
      op == OP_BR:  cls = 4'd4;
      op == OP_LUI: cls = 4'd5;
      op == OP_AUI: cls = 4'd6;
      op == OP_JAL: cls = 4'd7;
      op == OP_JR:  cls = 4'd8;
      default:      cls = 4'd9;
    endcase
  end

  always_comb begin
    inc = '0;
    for (int i = 0; i < 10; i++) begin
      inc[i] = count_en && (cls == 4'(i));
    end
    inc[10] = count_en;
    inc[11] = tick;
  end

  // Wrap detection uses the pre-increment all-ones value.
  always_comb begin
    ovf_d     = ovf_q;
    last_pc_d = last_pc_q;
    for (int i = 0; i < NCNT; i++) begin
      cnt_d[i] = cnt_q[i] + CNT_W'(inc[i]);
      if (inc[i] && (&cnt_q[i])) begin
        ovf_d[i] = 1'b1;
      end
    end
    if (count_en) begin
      last_pc_d = retire_pc;
    end
    if (cnt_clr) begin
      for (int i = 0; i < NCNT; i++) begin
        cnt_d[i] = '0;
      end
      ovf_d     = '0;
      last_pc_d = '0;
    end
  end

  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NCNT; i++) begin
      if (rd_sel == 4'(i)) begin
        rd_data_d = cnt_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCNT; i++) begin
        cnt_q[i] <= '0;
      end
      ovf_q     <= '0;
      last_pc_q <= '0;
      rd_data_q <= '0;
    end else begin
      for (int i = 0; i < NCNT; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      ovf_q     <= ovf_d;
      last_pc_q <= last_pc_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign ovf_flags = ovf_q;
  assign last_pc   = last_pc_q;

`ifdef PERF_TRACE_EN
`ifndef SYNTHESIS
  logic trace_clr_q;

  always @(posedge clk) begin
    trace_clr_q <= cnt_clr;
    if (count_en) begin
      $display("perf: pc=%0d instr=%h", retire_pc, retire_instr);
    end
    if (cnt_clr && !trace_clr_q) begin
      $display("perf: clr %0d %0d %0d %0d %0d %0d %0d %0d %0d %0d %0d %0d",
               cnt_q[0], cnt_q[1], cnt_q[2], cnt_q[3],
               cnt_q[4], cnt_q[5], cnt_q[6], cnt_q[7],
               cnt_q[8], cnt_q[9], cnt_q[10], cnt_q[11]);
    end
  end
`endif
`else
`endif

endmodule

// File: tb/tb_exec_perf_counters.sv
// tb_exec_perf_counters: directed checks of exec_perf_counters (CNT_W=8).
module tb_exec_perf_counters;

  localparam int CNT_W   = 8;
  localparam int PC_W    = 16;
  localparam int INSTR_W = 32;

  logic               clk;
  logic               rst_n;
  logic               retire_valid;
  logic               retire_flush;
  logic [INSTR_W-1:0] retire_instr;
  logic [PC_W-1:0]    retire_pc;
  logic               cnt_clr;
  logic               cnt_freeze;
  logic [3:0]         rd_sel;
  logic [CNT_W-1:0]   rd_data;
  logic [11:0]        ovf_flags;
  logic [PC_W-1:0]    last_pc;

  int errors = 0;
  int checks = 0;

  exec_perf_counters #(
    .CNT_W  (CNT_W),
    .PC_W   (PC_W),
    .INSTR_W(INSTR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .retire_valid(retire_valid),
    .retire_flush(retire_flush),
    .retire_instr(retire_instr),
    .retire_pc   (retire_pc),
    .cnt_clr     (cnt_clr),
    .cnt_freeze  (cnt_freeze),
    .rd_sel      (rd_sel),
    .rd_data     (rd_data),
    .ovf_flags   (ovf_flags),
    .last_pc     (last_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input int i,
                        input logic [31:0] exp,
                        input string tag);
    rd_sel = 4'(i);
    step();
    chk(tag, 32'(rd_data), exp);
  endtask

  task automatic clear();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
  endtask

  logic [31:0] exp_sw [16];

  initial begin
    rst_n        = 1'b0;
    retire_valid = 1'b0;
    retire_flush = 1'b0;
    retire_instr = '0;
    retire_pc    = '0;
    cnt_clr      = 1'b0;
    cnt_freeze   = 1'b0;
    rd_sel       = 4'd11;

    #2;
    chk("rst_rd", 32'(rd_data), 32'd0);
    chk("rst_ovf", 32'(ovf_flags), 32'd0);
    chk("rst_pc", 32'(last_pc), 32'd0);
    #10 rst_n = 1'b1;

    // Five idle edges: CYCLES read lags by one.
    for (int k = 0; k < 5; k++) step();
    chk("idle_cyc", 32'(rd_data), 32'd4);
    for (int i = 0; i < 11; i++) begin
      rd_chk(i, 32'd0, $sformatf("idle_c%0d", i));
    end
    chk("idle_ovf", 32'(ovf_flags), 32'd0);

    clear();
    retire_valid = 1'b1;
    retire_instr = 32'h00A00093;
    retire_pc    = 16'd0;
    step();
    retire_instr = 32'h002081B3;
    retire_pc    = 16'd4;
    step();
    retire_instr = 32'h0000A103;
    retire_pc    = 16'd8;
    step();
    retire_valid = 1'b0;
    chk("mix_pc", 32'(last_pc), 32'd8);
    rd_chk(1, 32'd1, "mix_i");
    rd_chk(0, 32'd1, "mix_r");
    rd_chk(3, 32'd1, "mix_ld");
    rd_chk(10, 32'd3, "mix_tot");

    clear();
    retire_flush = 1'b1;
    retire_instr = 32'h000012B7;
    step();
    retire_valid = 1'b1;
    retire_instr = 32'h00000063;
    step();
    retire_flush = 1'b0;
    retire_instr = 32'hFFFFFFFF;
    retire_pc    = 16'h0040;
    step();
    retire_valid = 1'b0;
    rd_chk(4, 32'd0, "fl_br");
    rd_chk(9, 32'd1, "fl_oth");
    rd_chk(10, 32'd1, "fl_tot");
    rd_chk(5, 32'd0, "fl_lui");
    chk("fl_pc", 32'(last_pc), 32'h40);

    // 256 retires wrap I-ALU, TOTAL and CYCLES back to zero.
    clear();
    retire_valid = 1'b1;
    retire_instr = 32'h00A00093;
    for (int k = 0; k < 256; k++) begin
      retire_pc = 16'(k * 4);
      step();
    end
    chk("wrap_ovf", 32'(ovf_flags), 32'hC02);
    retire_pc = 16'd1024;
    step();
    retire_valid = 1'b0;
    chk("wrap_ovf2", 32'(ovf_flags), 32'hC02);
    chk("wrap_pc", 32'(last_pc), 32'h400);
    rd_chk(1, 32'd1, "wrap_i");
    rd_chk(10, 32'd1, "wrap_tot");

    retire_valid = 1'b1;
    retire_instr = 32'h000012B7;
    retire_pc    = 16'h0100;
    cnt_clr      = 1'b1;
    step();
    cnt_clr      = 1'b0;
    retire_valid = 1'b0;
    chk("clr_ovf", 32'(ovf_flags), 32'd0);
    chk("clr_pc", 32'(last_pc), 32'd0);
    rd_chk(5, 32'd0, "clr_lui");
    rd_chk(10, 32'd0, "clr_tot");

    clear();
    retire_valid = 1'b1;
    retire_instr = 32'h0000006F;
    retire_pc    = 16'h0020;
    step();
    retire_valid = 1'b0;
    cnt_freeze   = 1'b1;
    retire_valid = 1'b1;
    retire_instr = 32'h00000063;
    for (int k = 0; k < 3; k++) begin
      retire_pc = 16'(16'h0080 + 16'(k * 4));
      step();
    end
    retire_valid = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("frz_pc", 32'(last_pc), 32'h20);
    chk("frz_ovf", 32'(ovf_flags), 32'd0);
    for (int i = 0; i < 16; i++) exp_sw[i] = 32'd0;
    exp_sw[7]  = 32'd1;
    exp_sw[10] = 32'd1;
    exp_sw[11] = 32'd1;
    for (int i = 0; i < 16; i++) begin
      rd_chk(i, exp_sw[i], $sformatf("frz_sw%0d", i));
    end
    rd_chk(7, 32'd1, "frz_pre");

    rst_n = 1'b0;
    #1;
    chk("arst_rd", 32'(rd_data), 32'd0);
    chk("arst_pc", 32'(last_pc), 32'd0);
    #1;
    rst_n      = 1'b1;
    cnt_freeze = 1'b0;
    rd_sel     = 4'd11;
    for (int k = 0; k < 3; k++) step();
    chk("post_cyc", 32'(rd_data), 32'd2);
    rd_chk(7, 32'd0, "post_jal");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
